// File: rtl/vga_scan_if.sv
// Bundle of the client-facing scan signals: coordinates and timing strobes
// out to the pixel source, colour back in, and the DAC/sync pins.
interface vga_scan_if;
    logic [11:0] PIXEL;
    logic [10:0] X;
    logic [10:0] Y;
    logic        ACTIVE;
    logic        FRAME;
    logic [3:0]  VGA_R;
    logic [3:0]  VGA_G;
    logic [3:0]  VGA_B;
    logic        VGA_HS;
    logic        VGA_VS;

    // The scan generator drives coordinates and DAC pins, reads colour.
    modport master (
        input  PIXEL,
        output X, Y, ACTIVE, FRAME,
        output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS
    );

    // The pixel source / monitor side.
    modport slave (
        output PIXEL,
        input  X, Y, ACTIVE, FRAME,
        input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS
    );
endinterface

// File: rtl/vga_scan.sv
// VGA scan generator: free-running x/y raster counters, combinational
// coordinates for the pixel source, and a PIPE-deep control delay line that
// re-aligns blanking and syncs with the colour returned by the client.
module vga_scan #(
    parameter int H_VISIBLE = 800,
    parameter int H_FRONT   = 56,
    parameter int H_SYNC    = 120,
    parameter int H_BACK    = 64,
    parameter int V_VISIBLE = 600,
    parameter int V_FRONT   = 37,
    parameter int V_SYNC    = 6,
    parameter int V_BACK    = 23,
    parameter bit HS_POL    = 1'b1,
    parameter bit VS_POL    = 1'b1,
    parameter int PIPE      = 2
) (
    input  logic      CLOCK,
    input  logic      RESET,
    vga_scan_if.master vga
);

    // Line/frame order is back porch, visible, front porch, sync.
    localparam int HW = H_BACK + H_VISIBLE + H_FRONT + H_SYNC;
    localparam int VW = V_BACK + V_VISIBLE + V_FRONT + V_SYNC;

    localparam logic [10:0] HW_M1    = 11'(HW - 1);
    localparam logic [10:0] VW_M1    = 11'(VW - 1);
    localparam logic [10:0] HA_START = 11'(H_BACK);
    localparam logic [10:0] HA_END   = 11'(H_BACK + H_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_BACK + H_VISIBLE + H_FRONT);
    localparam logic [10:0] VA_START = 11'(V_BACK);
    localparam logic [10:0] VA_END   = 11'(V_BACK + V_VISIBLE);
    localparam logic [10:0] VS_START = 11'(V_BACK + V_VISIBLE + V_FRONT);

    if (HW > 2047 || VW > 2047) begin : g_bad_sum
        $error("vga_scan: horizontal or vertical total exceeds 2047");
    end
    if (PIPE < 0 || PIPE > 4) begin : g_bad_pipe
        $error("vga_scan: PIPE must be within 0..4");
    end

    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        active_c;
    logic        hs_raw_c;
    logic        vs_raw_c;
    logic [2:0]  ctl_now;   // {active, hsync, vsync} at the counter position
    logic [2:0]  ctl_dly;   // same, PIPE clocks later
    logic [11:0] rgb_q, rgb_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;

    // Raster advance: x wraps every line, y steps only on the x wrap.
    always_comb begin
        x_d = x_q + 11'd1;
        y_d = y_q;
        if (x_q == HW_M1) begin
            x_d = 11'd0;
            y_d = (y_q == VW_M1) ? 11'd0 : y_q + 11'd1;
        end
    end

    // Counter registers; reset aborts the scan and restarts at the frame origin.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            x_q <= 11'd0;
            y_q <= 11'd0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign active_c = (x_q >= HA_START) && (x_q < HA_END) &&
                      (y_q >= VA_START) && (y_q < VA_END);
    assign hs_raw_c = (x_q >= HS_START);
    assign vs_raw_c = (y_q >= VS_START);
    assign ctl_now  = {active_c, hs_raw_c, vs_raw_c};

    // Coordinates and frame strobe go to the client undelayed.
    assign vga.X      = x_q - HA_START;
    assign vga.Y      = y_q - VA_START;
    assign vga.ACTIVE = active_c;
    assign vga.FRAME  = (x_q == 11'd0) && (y_q == 11'd0);

    // ---- stage boundary: control delay line matching the client latency ----
    if (PIPE == 0) begin : g_nopipe
        assign ctl_dly = ctl_now;
    end else begin : g_pipe
        logic [2:0] pipe_q [PIPE];

        // Shift blanking/sync state; reset fills every stage with "inactive".
        always_ff @(posedge CLOCK) begin
            if (RESET) begin
                for (int i = 0; i < PIPE; i++) pipe_q[i] <= 3'b000;
            end else begin
                pipe_q[0] <= ctl_now;
                for (int i = 1; i < PIPE; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end

        assign ctl_dly = pipe_q[PIPE-1];
    end

    // Blank colour outside the delayed visible window; apply sync polarity.
    always_comb begin
        rgb_d = ctl_dly[2] ? vga.PIXEL : 12'h000;
        hs_d  = ~(ctl_dly[1] ^ HS_POL);
        vs_d  = ~(ctl_dly[0] ^ VS_POL);
    end

    // ---- stage boundary: DAC output register ----
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            rgb_q <= 12'h000;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
        end
    end

    assign vga.VGA_R  = rgb_q[11:8];
    assign vga.VGA_G  = rgb_q[7:4];
    assign vga.VGA_B  = rgb_q[3:0];
    assign vga.VGA_HS = hs_q;
    assign vga.VGA_VS = vs_q;

endmodule
